pps_correction_ctrl: RTL and testbench
======================================

PPS_CORRECTION_CTRL -- requirements
Module: pps_correction_ctrl

Interface
REQ-001 SHALL have parameter TIMESTAMP_WIDTH, default 64, width of timestamp and time_pps.
REQ-002 SHALL have parameter PPS_PERIOD, default 160000000, nominal clk cycles between PPS edges.
REQ-003 SHALL have parameter PPS_TOL, default 1000, allowed +/- deviation in cycles from PPS_PERIOD.
REQ-004 SHALL have parameter LOCK_COUNT, default 4, consecutive good intervals needed to lock.
REQ-005 SHALL have port clk, input, 1, sole clock; one clock domain.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port pps_in, input, 2, asynchronous PPS sources; bit 0 primary, bit 1 secondary.
REQ-008 SHALL have port src_enable, input, 2, per-source enable.
REQ-009 SHALL have port src_pref, input, 1, preferred source index.
REQ-010 SHALL have port timestamp, input, TIMESTAMP_WIDTH, free-running local time.
REQ-011 SHALL have port time_pps, output, TIMESTAMP_WIDTH, timestamp captured at forwarded edge.
REQ-012 SHALL have port pps_valid, output, 1, one-cycle strobe qualifying time_pps.
REQ-013 SHALL have port correction_mode, output, 1, enables DDS update downstream.
REQ-014 SHALL have ports active_src (1), locked (1) and bad_pps_cnt (16), all outputs, for status.

Function
REQ-015 SHALL pass each pps_in bit through a 2-flop synchronizer plus a third delay flop; edge[i] = s2 & ~s3.
REQ-016 SHALL ignore edges on the non-active source and on disabled sources.
REQ-017 SHALL keep a 32-bit interval counter that clears on every accepted or rejected active edge, increments otherwise and saturates at PPS_PERIOD+PPS_TOL+1.
REQ-018 SHALL classify an active edge as good iff counter is in [PPS_PERIOD-PPS_TOL, PPS_PERIOD+PPS_TOL] and have_ref=1.
REQ-019 SHALL, for a forwarded edge, register time_pps <= timestamp and pps_valid <= 1 on the clock edge following the edge[i] cycle; pps_valid lasts exactly one cycle.
REQ-020 SHALL implement states IDLE, ACQUIRE, LOCKED, HOLDOVER; correction_mode=1 only in LOCKED; locked = (state==LOCKED).
REQ-021 IDLE: entered when src_enable==0; edges ignored; on any enable set, active_src = src_pref if that source is enabled, else the enabled one; go to ACQUIRE.
REQ-022 ACQUIRE: first active edge with have_ref=0 is forwarded, sets have_ref, good_cnt=0; good edge is forwarded, good_cnt+1; on reaching LOCK_COUNT go to LOCKED.
REQ-023 ACQUIRE/LOCKED: a bad edge is not forwarded, clears good_cnt, increments bad_pps_cnt (saturating at 16'hFFFF), keeps have_ref=1; LOCKED goes to ACQUIRE.
REQ-024 LOCKED: good edges are forwarded; counter saturating without an edge goes to HOLDOVER.
REQ-025 ACQUIRE with have_ref=1: counter saturation clears have_ref and good_cnt; stays ACQUIRE.
REQ-026 HOLDOVER: if the other source is enabled, switch active_src, clear have_ref, go to ACQUIRE next cycle; else the next active edge is treated as first (forwarded) in ACQUIRE.
REQ-027 SHALL restart acquisition (have_ref=0, good_cnt=0, ACQUIRE) one cycle after src_pref changes to an enabled source or the active source is disabled; go to IDLE if none enabled.
REQ-028 Edge and counter saturation in the same cycle: the edge takes priority.
REQ-029 Configuration change and active edge in the same cycle: the configuration change wins; the edge is dropped and not counted.

Reset
REQ-030 SHALL on reset set state=IDLE, have_ref=0, good_cnt=0, counter=0, sync flops=0, pps_valid=0, time_pps=0, correction_mode=0, locked=0, active_src=0, bad_pps_cnt=0.
REQ-031 Reset asserted mid-operation SHALL abort within one cycle: no pps_valid in the cycle after reset is sampled.

Verification (PPS_PERIOD=1000, PPS_TOL=10, LOCK_COUNT=4)
REQ-032 src_enable=01, pulses on pps_in[0] every 1000 cycles -> 5 pps_valid strobes; locked=1 and correction_mode=1 after the 5th strobe; time_pps = timestamp at each strobe.
REQ-033 Locked; one pulse arrives 500 cycles early -> no strobe; bad_pps_cnt=1; state ACQUIRE; correction_mode=0 next cycle.
REQ-034 Locked, src_enable=11; primary stops -> HOLDOVER at counter 1011; active_src=1 next cycle; relock after 5 secondary pulses.
REQ-035 Pulse on pps_in[1] while active_src=0 -> no strobe and no counter change.
REQ-036 Pulses at interval 990 and 1010 -> accepted; interval 989 or 1011 -> rejected.
REQ-037 Reset pulsed while locked -> all outputs equal REQ-030 values; full 5-pulse acquisition is required to relock.

Source files
------------

// File: rtl/pps_correction_ctrl.sv
// pps_correction_ctrl
// Selects one of two asynchronous PPS sources and measures the interval
// between its edges against the nominal period. Qualified edges are
// forwarded as a timestamp strobe, and a four-state machine reports lock.
// Correction of the downstream DDS is enabled only while locked.
module pps_correction_ctrl #(
   parameter int TIMESTAMP_WIDTH = 64,
   parameter int PPS_PERIOD      = 160000000,
   parameter int PPS_TOL         = 1000,
   parameter int LOCK_COUNT      = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 pps_in,
   input  logic [1:0]                 src_enable,
   input  logic                       src_pref,
   input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
   output logic [TIMESTAMP_WIDTH-1:0] time_pps,
   output logic                       pps_valid,
   output logic                       correction_mode,
   output logic                       active_src,
   output logic                       locked,
   output logic [15:0]                bad_pps_cnt
);

   // Acceptance window and counter ceiling, all in clk cycles.
   localparam logic [31:0] CNT_LO  = 32'(PPS_PERIOD - PPS_TOL);
   localparam logic [31:0] CNT_HI  = 32'(PPS_PERIOD + PPS_TOL);
   localparam logic [31:0] CNT_SAT = 32'(PPS_PERIOD + PPS_TOL + 1);

   localparam int              GW        = $clog2(LOCK_COUNT + 1);
   localparam logic [GW-1:0]   GOOD_LAST = GW'(LOCK_COUNT - 1);
   localparam logic [GW-1:0]   GOOD_FULL = GW'(LOCK_COUNT);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2,
      ST_HOLDOVER = 2'd3
   } state_t;

   // Synchronizer chain and edge detect.
   logic [1:0]    r_sync1;
   logic [1:0]    r_sync2;
   logic [1:0]    r_sync3;
   logic [1:0]    w_edge;

   // Control state.
   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_have_ref;
   logic          w_have_ref_nxt;
   logic [GW-1:0] r_good_cnt;
   logic [GW-1:0] w_good_cnt_nxt;
   logic          r_active;
   logic          w_active_nxt;
   logic [15:0]   r_bad_cnt;
   logic          w_bad_inc;
   logic          r_pref_q;

   // Interval measurement and forwarding.
   logic [31:0]                r_cnt;
   logic                       w_fwd;
   logic                       r_pps_valid;
   logic [TIMESTAMP_WIDTH-1:0] r_time_pps;

   // Decoded conditions.
   logic          w_none;
   logic          w_act_dis;
   logic          w_pref_chg;
   logic          w_cfg;
   logic          w_edge_act;
   logic          w_in_win;
   logic          w_sat;
   logic          w_first;
   logic          w_good;
   logic          w_bad;
   logic          w_idle_sel;

   // Two flops to resolve metastability, a third to detect the rising edge.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_sync3 <= '0;
      end else begin
         r_sync1 <= pps_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_edge = r_sync2 & ~r_sync3;

   // Configuration events. A changed preference only matters if the newly
   // preferred source is actually enabled.
   assign w_none     = (src_enable == 2'b00);
   assign w_act_dis  = ~src_enable[r_active];
   assign w_pref_chg = (src_pref != r_pref_q) && src_enable[src_pref];
   assign w_cfg      = (r_state != ST_IDLE) && (w_none || w_act_dis || w_pref_chg);

   // Only the active source's edge counts, never in IDLE, and a simultaneous
   // configuration change swallows it.
   assign w_edge_act = w_edge[r_active] && (r_state != ST_IDLE) && !w_cfg;

   assign w_in_win = (r_cnt >= CNT_LO) && (r_cnt <= CNT_HI);
   assign w_sat    = (r_cnt == CNT_SAT);
   assign w_first  = w_edge_act && !r_have_ref;
   assign w_good   = w_edge_act &&  r_have_ref &&  w_in_win;
   assign w_bad    = w_edge_act &&  r_have_ref && !w_in_win;

   // Leaving IDLE: preferred source if enabled, otherwise the other one.
   assign w_idle_sel = src_enable[src_pref] ? src_pref : ~src_pref;

   // Cycles since the last active edge. The cycle after an edge is already
   // one cycle into the new interval, so the count restarts at 1 and reads
   // exactly the edge-to-edge spacing when the next edge arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_edge_act) begin
         r_cnt <= 32'd1;
      end else if (r_cnt != CNT_SAT) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   // Next-state, reference tracking, source selection and forward decision.
   // NOTE: every output of this block gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_have_ref_nxt = r_have_ref;
      w_good_cnt_nxt = r_good_cnt;
      w_active_nxt   = r_active;
      w_bad_inc      = 1'b0;
      w_fwd          = 1'b0;

      if (r_state == ST_IDLE) begin
         if (!w_none) begin
            w_active_nxt   = w_idle_sel;
            w_have_ref_nxt = 1'b0;
            w_good_cnt_nxt = '0;
            w_state_nxt    = ST_ACQUIRE;
         end
      end else if (w_none) begin
         w_have_ref_nxt = 1'b0;
         w_good_cnt_nxt = '0;
         w_state_nxt    = ST_IDLE;
      end else if (w_act_dis) begin
         // The other source must be enabled, otherwise w_none would be set.
         w_active_nxt   = ~r_active;
         w_have_ref_nxt = 1'b0;
         w_good_cnt_nxt = '0;
         w_state_nxt    = ST_ACQUIRE;
      end else if (w_pref_chg) begin
         w_active_nxt   = src_pref;
         w_have_ref_nxt = 1'b0;
         w_good_cnt_nxt = '0;
         w_state_nxt    = ST_ACQUIRE;
      end else begin
         unique case (r_state)
            ST_ACQUIRE: begin
               if (w_first) begin
                  w_fwd          = 1'b1;
                  w_have_ref_nxt = 1'b1;
                  w_good_cnt_nxt = '0;
               end else if (w_good) begin
                  w_fwd = 1'b1;
                  if (r_good_cnt == GOOD_LAST) begin
                     w_good_cnt_nxt = GOOD_FULL;
                     w_state_nxt    = ST_LOCKED;
                  end else begin
                     w_good_cnt_nxt = r_good_cnt + 1'b1;
                  end
               end else if (w_bad) begin
                  // The rejected edge still becomes the new reference.
                  w_good_cnt_nxt = '0;
                  w_bad_inc      = 1'b1;
               end else if (w_sat && r_have_ref) begin
                  // Reference went stale; the next edge starts over.
                  w_have_ref_nxt = 1'b0;
                  w_good_cnt_nxt = '0;
               end
            end
            ST_LOCKED: begin
               if (w_good) begin
                  w_fwd = 1'b1;
               end else if (w_bad) begin
                  w_good_cnt_nxt = '0;
                  w_bad_inc      = 1'b1;
                  w_state_nxt    = ST_ACQUIRE;
               end else if (w_sat) begin
                  w_state_nxt = ST_HOLDOVER;
               end
            end
            ST_HOLDOVER: begin
               if (src_enable[~r_active]) begin
                  w_active_nxt   = ~r_active;
                  w_have_ref_nxt = 1'b0;
                  w_good_cnt_nxt = '0;
                  w_state_nxt    = ST_ACQUIRE;
               end else if (w_edge_act) begin
                  // Same source returns: its edge is a fresh first reference.
                  w_fwd          = 1'b1;
                  w_have_ref_nxt = 1'b1;
                  w_good_cnt_nxt = '0;
                  w_state_nxt    = ST_ACQUIRE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State register plus the status counters that follow the FSM decision.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_have_ref <= 1'b0;
         r_good_cnt <= '0;
         r_active   <= 1'b0;
         r_bad_cnt  <= '0;
         r_pref_q   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_have_ref <= w_have_ref_nxt;
         r_good_cnt <= w_good_cnt_nxt;
         r_active   <= w_active_nxt;
         r_pref_q   <= src_pref;
         if (w_bad_inc && (r_bad_cnt != 16'hFFFF)) begin
            r_bad_cnt <= r_bad_cnt + 16'd1;
         end
      end
   end

   // Capture the local time in the cycle after a forwarded edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pps_valid <= 1'b0;
         r_time_pps  <= '0;
      end else begin
         r_pps_valid <= w_fwd;
         if (w_fwd) begin
            r_time_pps <= timestamp;
         end
      end
   end

   assign time_pps        = r_time_pps;
   assign pps_valid       = r_pps_valid;
   assign correction_mode = (r_state == ST_LOCKED);
   assign locked          = (r_state == ST_LOCKED);
   assign active_src      = r_active;
   assign bad_pps_cnt     = r_bad_cnt;

endmodule

// File: tb/tb_pps_correction_ctrl.sv
// Testbench for pps_correction_ctrl with a short period for fast runs.
// Directed vectors come from a table; randomized intervals are checked
// against an interval-level model of the acquisition rules.
module tb_pps_correction_ctrl;

   localparam int P   = 1000;
   localparam int T   = 10;
   localparam int L   = 4;
   localparam int TSW = 64;

   logic           clk = 1'b0;
   logic           reset;
   logic [1:0]     pps_in;
   logic [1:0]     src_enable;
   logic           src_pref;
   logic [TSW-1:0] ts = 64'h0123_4567_89AB_0000;
   logic [TSW-1:0] time_pps;
   logic           pps_valid;
   logic           correction_mode;
   logic           active_src;
   logic           locked;
   logic [15:0]    bad_pps_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Interval-level model state.
   logic m_have;
   logic m_locked;
   int   m_good;
   int   m_bad;

   typedef struct {
      logic src;
      logic fwd;
      logic lck;
      int   bad;
      int   wait_after;
   } vec_t;

   vec_t tbl[15];
   int   ivals[11] = '{500, 989, 990, 991, 1000, 1000, 1009, 1010, 1011, 1012, 1400};

   pps_correction_ctrl #(
      .TIMESTAMP_WIDTH(TSW),
      .PPS_PERIOD     (P),
      .PPS_TOL        (T),
      .LOCK_COUNT     (L)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pps_in         (pps_in),
      .src_enable     (src_enable),
      .src_pref       (src_pref),
      .timestamp      (ts),
      .time_pps       (time_pps),
      .pps_valid      (pps_valid),
      .correction_mode(correction_mode),
      .active_src     (active_src),
      .locked         (locked),
      .bad_pps_cnt    (bad_pps_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ts <= ts + 64'd1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check("no spurious strobe", pps_valid, 0);
      end
   endtask

   // Acquisition rules applied to one active-source edge arriving d cycles
   // after the previous one. Past PERIOD+TOL+1 cycles the counter has already
   // hit its ceiling, so the reference is stale and the edge counts as first.
   task automatic model_edge(input int d, output logic fwd);
      if (!m_have || d > P + T + 1) begin
         m_have   = 1'b1;
         m_good   = 0;
         m_locked = 1'b0;
         fwd      = 1'b1;
      end else if (d >= P - T && d <= P + T) begin
         if (!m_locked) begin
            m_good++;
            if (m_good == L) m_locked = 1'b1;
         end
         fwd = 1'b1;
      end else begin
         m_good   = 0;
         m_locked = 1'b0;
         if (m_bad < 65535) m_bad++;
         fwd = 1'b0;
      end
   endtask

   // Drive a 3-cycle pulse on one source, then run wait_after cycles in
   // total. Two sync stages plus the output register put the strobe three
   // cycles after the pulse starts; every other cycle must be quiet.
   task automatic pulse(input logic src, input logic e_fwd, input logic e_lck,
                        input int e_bad, input int wait_after, input string tag);
      pps_in[src] = 1'b1;
      for (int j = 1; j <= wait_after; j++) begin
         tick();
         if (j == 3) begin
            pps_in[src] = 1'b0;
            check({tag, " valid"}, pps_valid, e_fwd);
            if (e_fwd) check({tag, " time_pps"}, time_pps, ts - 64'd1);
            check({tag, " locked"}, locked, e_lck);
            check({tag, " correction_mode"}, correction_mode, e_lck);
            check({tag, " bad_pps_cnt"}, bad_pps_cnt, e_bad);
         end else begin
            check({tag, " quiet"}, pps_valid, 0);
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " pps_valid"}, pps_valid, 0);
      check({tag, " time_pps"}, time_pps, 0);
      check({tag, " locked"}, locked, 0);
      check({tag, " correction_mode"}, correction_mode, 0);
      check({tag, " active_src"}, active_src, 0);
      check({tag, " bad_pps_cnt"}, bad_pps_cnt, 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t_unlock;
      int   t_sw;
      int   d_prev;
      int   d_next;
      logic e_fwd;

      // src, fwd, locked, bad, cycles until next pulse
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, 1000};  // first edge
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 0, 1000};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 0, 1000};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 0, 1000};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 0,  500};  // fifth strobe locks
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1,  990};  // 500 early: rejected
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1, 1010};  // interval 990 accepted
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1,  989};  // interval 1010 accepted
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 2, 1011};  // interval 989 rejected
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 3,  400};  // interval 1011 rejected
      tbl[10] = '{1'b1, 1'b0, 1'b0, 3,  600};  // disabled source ignored
      tbl[11] = '{1'b0, 1'b1, 1'b0, 3, 1000};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 3, 1000};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 3, 1000};
      tbl[14] = '{1'b0, 1'b1, 1'b1, 3,    4};  // relocked

      reset      = 1'b1;
      pps_in     = 2'b00;
      src_enable = 2'b00;
      src_pref   = 1'b0;
      repeat (3) tick();
      check_reset_values("reset");
      reset = 1'b0;
      tick();

      // No source enabled: edges must be ignored.
      pulse(1'b0, 1'b0, 1'b0, 0, 20, "idle");

      src_enable = 2'b01;
      idle(5);
      for (int i = 0; i < 15; i++) begin
         pulse(tbl[i].src, tbl[i].fwd, tbl[i].lck, tbl[i].bad,
               tbl[i].wait_after, $sformatf("vec%0d", i));
      end

      // Primary goes silent with the secondary available: holdover, then
      // switch to the secondary one cycle after lock is lost.
      src_enable = 2'b11;
      t_unlock   = -1;
      t_sw       = -1;
      for (int j = 5; j <= 1100 && t_sw < 0; j++) begin
         tick();
         check("holdover quiet", pps_valid, 0);
         if (t_unlock < 0 && locked == 1'b0) t_unlock = j;
         if (t_sw < 0 && active_src == 1'b1) t_sw = j;
      end
      check("holdover switch seen", (t_sw >= 0), 1);
      if (t_sw >= 0) begin
         check("switch one cycle after unlock", t_sw, t_unlock + 1);
         check("unlock near ceiling", (t_unlock >= P + T + 1 && t_unlock <= P + T + 6), 1);
      end
      idle(10);

      // Relock on the secondary.
      m_have   = 1'b0;
      m_good   = 0;
      m_locked = 1'b0;
      m_bad    = 3;
      for (int k = 0; k < 5; k++) begin
         model_edge((k == 0) ? 100000 : P, e_fwd);
         pulse(1'b1, e_fwd, m_locked, m_bad, P, "relock sec");
      end
      check("relock sec locked", locked, 1);
      check("relock sec active", active_src, 1);

      // Reset sampled in the same cycle as a forwarded edge: no strobe.
      pps_in[1] = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      pps_in[1] = 1'b0;
      check_reset_values("mid reset");
      tick();
      check_reset_values("mid reset hold");
      reset = 1'b0;
      idle(5);
      check("post reset active", active_src, 0);

      // Full acquisition again, with a stray pulse on the enabled but
      // non-active secondary in the middle of an interval.
      m_have   = 1'b0;
      m_good   = 0;
      m_locked = 1'b0;
      m_bad    = 0;
      for (int k = 0; k < 5; k++) begin
         model_edge((k == 0) ? 100000 : P, e_fwd);
         if (k == 2) begin
            pulse(1'b0, e_fwd, m_locked, m_bad, 400, "reacq");
            pulse(1'b1, 1'b0, m_locked, m_bad, 600, "non-active src");
         end else begin
            pulse(1'b0, e_fwd, m_locked, m_bad, P, "reacq");
         end
      end
      check("reacq locked", locked, 1);

      // Randomized intervals on a single source.
      src_enable = 2'b01;
      d_prev     = P;
      for (int k = 0; k < 30; k++) begin
         d_next = ivals[$urandom_range(0, 10)];
         model_edge(d_prev, e_fwd);
         pulse(1'b0, e_fwd, m_locked, m_bad, d_next, $sformatf("rand%0d d=%0d", k, d_prev));
         d_prev = d_next;
      end

      // Preference change in the same cycle as an active edge: the edge is
      // dropped and the switch still happens.
      src_enable = 2'b11;
      idle(3);
      pps_in[0] = 1'b1;
      tick();
      tick();
      src_pref = 1'b1;
      tick();
      pps_in[0] = 1'b0;
      check("cfg+edge no strobe", pps_valid, 0);
      check("cfg+edge active", active_src, 1);
      check("cfg+edge bad_pps_cnt", bad_pps_cnt, m_bad);
      check("cfg+edge locked", locked, 0);
      idle(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
